// File: rtl/dsa_verify.sv
// DSA signature verifier: range check, w = s^(q-2), u1/u2 scaling, g^u1*y^u2 mod p mod q, compare to r.
// Cycles after the start edge: CHECK 1, INV 2*LEN+3, SCAL 4, EXP 4*LEN+3, MULP 2, REDQ 2, FIN 1 = 6*LEN+16.
module dsa_verify #(
    parameter int unsigned LEN = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [LEN-1:0] p,
    input  logic [LEN-1:0] q,
    input  logic [LEN-1:0] g,
    input  logic [LEN-1:0] y,
    input  logic [LEN-1:0] z,
    input  logic [LEN-1:0] r,
    input  logic [LEN-1:0] s,
    input  logic [LEN-1:0] p_prime,
    input  logic [LEN-1:0] r2_mod_p,
    input  logic [LEN-1:0] q_prime,
    input  logic [LEN-1:0] r2_mod_q,
    output logic           valid,
    output logic           done
);
    localparam int unsigned W0 = LEN + 1;
    localparam int unsigned W2 = 2 * LEN;
    localparam int unsigned W1 = 2 * LEN + 1;
    localparam int unsigned CW = $clog2(4 * LEN + 4);
    localparam logic [CW-1:0] INV_LAST = CW'(2 * LEN + 2);
    localparam logic [CW-1:0] EXP_MID  = CW'(2 * LEN + 2);
    localparam logic [CW-1:0] EXP_LAST = CW'(4 * LEN + 2);
    localparam logic [LEN-1:0] ONE     = LEN'(1);

    typedef enum logic [2:0] {
        IDLE, CHECK, INV, SCAL, EXP, MULP, REDQ, FIN
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_mul;
    logic           r_ok;
    logic [LEN-1:0] r_p, r_q, r_g, r_y, r_z, r_r, r_s, r_pp, r_r2p, r_qp, r_r2q;
    logic [LEN-1:0] r_acc, r_base, r_exp, r_one, r_a, r_w, r_u1, r_u2, r_t;

    logic [LEN-1:0] w_mm_a, w_mm_b, w_n, w_np, w_m, w_res;
    logic           w_use_q;
    logic [W2-1:0]  w_t, w_mn;
    logic [W1-1:0]  w_sum;
    logic [W0-1:0]  w_red;

    // Operand and modulus selection for the single shared Montgomery multiplier.
    always_comb begin
        w_mm_a  = '0;
        w_mm_b  = '0;
        w_use_q = 1'b0;
        case (r_state)
            INV: begin
                w_use_q = 1'b1;
                if (r_cnt == '0) begin
                    w_mm_a = r_s;   w_mm_b = r_r2q;
                end else if (r_cnt == CW'(1)) begin
                    w_mm_a = ONE;   w_mm_b = r_r2q;
                end else if (r_cnt == INV_LAST) begin
                    w_mm_a = r_acc; w_mm_b = ONE;
                end else begin
                    w_mm_a = r_acc; w_mm_b = r_mul ? r_base : r_acc;
                end
            end
            SCAL: begin
                w_use_q = 1'b1;
                case (r_cnt[1:0])
                    2'd0:    begin w_mm_a = r_z; w_mm_b = r_r2q; end
                    2'd2:    begin w_mm_a = r_r; w_mm_b = r_r2q; end
                    default: begin w_mm_a = r_t; w_mm_b = r_w;   end
                endcase
            end
            EXP: begin
                if (r_cnt == '0) begin
                    w_mm_a = ONE;   w_mm_b = r_r2p;
                end else if (r_cnt == CW'(1)) begin
                    w_mm_a = r_g;   w_mm_b = r_r2p;
                end else if (r_cnt == EXP_MID) begin
                    w_mm_a = r_y;   w_mm_b = r_r2p;
                end else begin
                    w_mm_a = r_acc; w_mm_b = r_mul ? r_base : r_acc;
                end
            end
            MULP: begin
                w_mm_a = (r_cnt == '0) ? r_a : r_t;
                w_mm_b = (r_cnt == '0) ? r_acc : ONE;
            end
            REDQ: begin
                w_use_q = 1'b1;
                w_mm_a  = r_t;
                w_mm_b  = (r_cnt == '0) ? r_r2q : ONE;
            end
            default: begin
                w_mm_a = '0;
                w_mm_b = '0;
            end
        endcase
    end

    // MM(a, b) = a*b*2^-LEN mod n with one conditional subtract.
    assign w_n   = w_use_q ? r_q : r_p;
    assign w_np  = w_use_q ? r_qp : r_pp;
    assign w_t   = W2'(w_mm_a) * W2'(w_mm_b);
    assign w_m   = w_t[LEN-1:0] * w_np;
    assign w_mn  = W2'(w_m) * W2'(w_n);
    assign w_sum = W1'(w_t) + W1'(w_mn);
    assign w_red = W0'(w_sum >> LEN);
    assign w_res = (w_red >= {1'b0, w_n}) ? LEN'(w_red - {1'b0, w_n}) : w_red[LEN-1:0];

    // Sequencer, operand registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mul   <= 1'b0;
            r_ok    <= 1'b0;
            {r_p, r_q, r_g, r_y, r_z, r_r, r_s} <= '0;
            {r_pp, r_r2p, r_qp, r_r2q}          <= '0;
            {r_acc, r_base, r_exp, r_one, r_a}  <= '0;
            {r_w, r_u1, r_u2, r_t}              <= '0;
            valid   <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_p <= p;  r_q <= q;  r_g <= g;  r_y <= y;
                    r_z <= z;  r_r <= r;  r_s <= s;
                    r_pp <= p_prime; r_r2p <= r2_mod_p;
                    r_qp <= q_prime; r_r2q <= r2_mod_q;
                    valid   <= 1'b0;
                    done    <= 1'b0;
                    r_state <= CHECK;
                end
                CHECK: begin
                    r_cnt <= '0;
                    r_mul <= 1'b0;
                    r_exp <= r_q - LEN'(2);
                    if (r_r == '0 || r_r >= r_q || r_s == '0 || r_s >= r_q) begin
                        r_ok    <= 1'b0;
                        r_state <= FIN;
                    end else begin
                        r_ok    <= 1'b1;
                        r_state <= INV;
                    end
                end
                INV: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == '0) begin
                        r_base <= w_res;
                    end else if (r_cnt == CW'(1)) begin
                        r_acc <= w_res;
                    end else if (r_cnt == INV_LAST) begin
                        r_w     <= w_res;
                        r_cnt   <= '0;
                        r_state <= SCAL;
                    end else if (!r_mul) begin
                        r_acc <= w_res;
                        r_mul <= 1'b1;
                    end else begin
                        if (r_exp[LEN-1]) r_acc <= w_res;
                        r_exp <= r_exp << 1;
                        r_mul <= 1'b0;
                    end
                end
                SCAL: begin
                    r_cnt <= r_cnt + CW'(1);
                    case (r_cnt[1:0])
                        2'd1:    r_u1 <= w_res;
                        2'd3: begin
                            r_u2    <= w_res;
                            r_cnt   <= '0;
                            r_state <= EXP;
                        end
                        default: r_t <= w_res;
                    endcase
                end
                EXP: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == '0) begin
                        r_acc <= w_res;
                        r_one <= w_res;
                        r_exp <= r_u1;
                        r_mul <= 1'b0;
                    end else if (r_cnt == CW'(1)) begin
                        r_base <= w_res;
                    end else if (r_cnt == EXP_MID) begin
                        // g^u1 stays in Montgomery form; restart the ladder on y.
                        r_a    <= r_acc;
                        r_base <= w_res;
                        r_acc  <= r_one;
                        r_exp  <= r_u2;
                        r_mul  <= 1'b0;
                    end else begin
                        if (!r_mul) begin
                            r_acc <= w_res;
                            r_mul <= 1'b1;
                        end else begin
                            if (r_exp[LEN-1]) r_acc <= w_res;
                            r_exp <= r_exp << 1;
                            r_mul <= 1'b0;
                        end
                        if (r_cnt == EXP_LAST) begin
                            r_cnt   <= '0;
                            r_state <= MULP;
                        end
                    end
                end
                MULP: begin
                    r_t   <= w_res;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt != '0) begin
                        r_cnt   <= '0;
                        r_state <= REDQ;
                    end
                end
                REDQ: begin
                    r_t   <= w_res;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt != '0) begin
                        r_cnt   <= '0;
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    valid   <= r_ok && (r_t == r_r);
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
